// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Each op costs 32 shift steps plus one sign-fixup cycle, so busy lasts 33 cycles.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO complete here in one cycle
// S_MUL  | radix-2 shift-add, one multiplier bit per cycle
// S_DIV  | restoring division, one quotient bit per cycle
// S_FIX  | apply result signs and write HI/LO
module mult_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs_i,
   input  logic [DATA_W-1:0] rt_i,
   input  logic              flush,
   input  logic              rd_hi,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [2*DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]     r_opnd;
   logic                  r_is_div;
   logic                  r_neg_res;
   logic                  r_neg_rem;
   logic                  r_div0;
   logic [DATA_W-1:0]     r_hi;
   logic [DATA_W-1:0]     r_lo;
   logic                  r_done;

   logic                  w_issue;
   logic                  w_is_md;
   logic                  w_signed;
   logic                  w_rs_neg;
   logic                  w_rt_neg;
   logic [DATA_W-1:0]     w_rs_mag;
   logic [DATA_W-1:0]     w_rt_mag;
   logic [DATA_W:0]       w_mul_sum;
   logic [2*DATA_W-1:0]   w_mul_next;
   logic [DATA_W:0]       w_rem_sh;
   logic [DATA_W:0]       w_diff;
   logic                  w_ge;
   logic [DATA_W-1:0]     w_rem_new;
   logic [2*DATA_W-1:0]   w_div_next;
   logic [2*DATA_W-1:0]   w_prod;
   logic [DATA_W-1:0]     w_quo;
   logic [DATA_W-1:0]     w_rem;

   assign w_issue  = start && !flush && (r_state == S_IDLE);
   assign w_is_md  = w_issue && !op[2];
   assign w_signed = !op[0];
   assign w_rs_neg = w_signed && rs_i[DATA_W-1];
   assign w_rt_neg = w_signed && rt_i[DATA_W-1];
   assign w_rs_mag = w_rs_neg ? -rs_i : rs_i;
   assign w_rt_mag = w_rt_neg ? -rt_i : rt_i;

   assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opnd};
   assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[DATA_W-1:1]}
                                : {1'b0, r_acc[2*DATA_W-1:1]};

   // Partial remainder lives in the upper half, dividend/quotient bits in the lower half.
   assign w_rem_sh   = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
   assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
   assign w_diff     = w_rem_sh - {1'b0, r_opnd};
   assign w_rem_new  = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
   assign w_div_next = {w_rem_new, r_acc[DATA_W-2:0], w_ge};

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quo  = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
   assign w_rem  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_is_md) w_next = op[1] ? S_DIV : S_MUL;
         S_MUL, S_DIV: begin
            if (flush)                 w_next = S_IDLE;
            else if (r_cnt == CNT_LAST) w_next = S_FIX;
         end
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIX) && !flush;
         case (r_state)
            S_IDLE: begin
               if (w_is_md) begin
                  r_cnt     <= '0;
                  r_acc     <= {{DATA_W{1'b0}}, w_rs_mag};
                  r_opnd    <= w_rt_mag;
                  r_is_div  <= op[1];
                  r_neg_res <= w_rs_neg ^ w_rt_neg;
                  r_neg_rem <= w_rs_neg;
                  r_div0    <= (rt_i == '0);
               end else if (w_issue && op == 3'b100) begin
                  r_hi <= rs_i;
               end else if (w_issue && op == 3'b101) begin
                  r_lo <= rs_i;
               end
            end
            S_MUL: begin
               r_acc <= w_mul_next;
               r_cnt <= r_cnt + CNT_ONE;
            end
            S_DIV: begin
               r_acc <= w_div_next;
               r_cnt <= r_cnt + CNT_ONE;
            end
            S_FIX: begin
               if (!flush) begin
                  if (r_is_div) begin
                     // Divide by zero leaves the dividend in the remainder, so HI comes back as rs.
                     r_hi <= w_rem;
                     r_lo <= r_div0 ? {DATA_W{1'b1}} : w_quo;
                  end else begin
                     r_hi <= w_prod[2*DATA_W-1:DATA_W];
                     r_lo <= w_prod[DATA_W-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign hi_o    = r_hi;
   assign lo_o    = r_lo;
   assign rdata_o = rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic corners, MTHI/MTLO, flush and mid-op reset.
module tb_mult_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic        flush;
   logic        rd_hi;
   logic        busy;
   logic        done;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [31:0] rdata_o;

   int          n_total;
   int          n_bad;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mult_div_unit #(.DATA_W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_i    (rs_i),
      .rt_i    (rt_i),
      .flush   (flush),
      .rd_hi   (rd_hi),
      .busy    (busy),
      .done    (done),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .rdata_o (rdata_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Returns at the negedge just after the issuing edge (first busy cycle).
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs_i = a; rt_i = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
      int n;
      issue(o, a, b);
      rd_hi = 1'b1;
      #1;
      chk({tag, "_hold_hi"}, {32'b0, rdata_o}, {32'b0, m_hi});
      wait_idle(n);
      chk({tag, "_cycles"}, 64'(n), 64'd33);
      chk({tag, "_done"}, {63'b0, done}, 64'd1);
      chk({tag, "_hi"}, {32'b0, hi_o}, {32'b0, eh});
      chk({tag, "_lo"}, {32'b0, lo_o}, {32'b0, el});
      rd_hi = 1'b0;
      #1;
      chk({tag, "_rdata_lo"}, {32'b0, rdata_o}, {32'b0, el});
      m_hi = eh;
      m_lo = el;
      @(negedge clk);
      chk({tag, "_done_drop"}, {63'b0, done}, 64'd0);
   endtask

   initial begin
      int  n;
      logic seen;
      n_total = 0; n_bad = 0;
      rst_n = 1'b0; start = 1'b0; op = 3'd0; rs_i = '0; rt_i = '0;
      flush = 1'b0; rd_hi = 1'b0; m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_hilo", {hi_o, lo_o}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_m2x3");
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
      run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1m1");
      run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
      run_op(3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by0");
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
      run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");

      // MTHI then MTLO on back-to-back edges
      @(negedge clk);
      start = 1'b1; op = 3'b100; rs_i = 32'h1234_5678;
      @(negedge clk);
      chk("mthi", {32'b0, hi_o}, 64'h1234_5678);
      op = 3'b101; rs_i = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo", {32'b0, lo_o}, 64'h9ABC_DEF0);
      chk("mt_busy", {62'b0, busy, done}, 64'd0);
      rd_hi = 1'b1; #1;
      chk("rdata_hi", {32'b0, rdata_o}, 64'h1234_5678);
      rd_hi = 1'b0; #1;
      chk("rdata_lo", {32'b0, rdata_o}, 64'h9ABC_DEF0);
      m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

      issue(3'b110, 32'hDEAD_BEEF, 32'h0000_0005);
      chk("noop_busy", {63'b0, busy}, 64'd0);
      @(negedge clk);
      chk("noop_hilo", {hi_o, lo_o}, {m_hi, m_lo});

      @(negedge clk);
      start = 1'b1; op = 3'b100; rs_i = 32'hCAFE_BABE; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("idle_flush_mthi", {32'b0, hi_o}, {32'b0, m_hi});
      chk("idle_flush_busy", {63'b0, busy}, 64'd0);

      // A second start while busy must not restart the operation
      issue(3'b001, 32'd5, 32'd7);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 3'b000; rs_i = 32'd2; rt_i = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      chk("busy_start_cycles", 64'(n), 64'd28);
      chk("busy_start_hilo", {hi_o, lo_o}, {32'd0, 32'd35});
      m_hi = 32'd0; m_lo = 32'd35;
      @(negedge clk);

      issue(3'b011, 32'd100, 32'd3);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {63'b0, busy}, 64'd0);
      seen = done;
      repeat (40) begin
         @(negedge clk);
         seen = seen | done;
      end
      chk("flush_no_done", {63'b0, seen}, 64'd0);
      chk("flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});

      // Flush landing on the sign-fixup cycle
      issue(3'b001, 32'd6, 32'd7);
      repeat (32) @(negedge clk);
      chk("fix_busy", {63'b0, busy}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fix_flush_state", {62'b0, busy, done}, 64'd0);
      chk("fix_flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});
      @(negedge clk);
      chk("fix_flush_done", {63'b0, done}, 64'd0);

      run_op(3'b011, 32'd100, 32'd3, 32'd1, 32'd33, "divu_100_3");

      issue(3'b001, 32'd5, 32'd7);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {62'b0, busy, done}, 64'd0);
      chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'b001, 32'd5, 32'd7, 32'd0, 32'd35, "multu_5x7");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
